vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single VRAM port shared by display reads and queued CPU writes.
// Ports: clk, rst_n; pix_req/pix_addr -> pix_granted/pix_stolen;
//   cpu_we/cpu_waddr/cpu_wdata -> cpu_ready, fifo_level, ovf (ovf_clr);
//   vram_addr/vram_we/vram_wdata registered port.
// Option: define VRAM_WR_STEAL_EN to let a full queue steal a read slot.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_granted,
    output logic              pix_stolen,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
    logic              vram_we_q, vram_we_d;
    logic              granted_q, granted_d;
    logic              ovf_q, ovf_d;
    logic              full, empty, push, pop, drop, steal;

    // Fullness is taken before any same-cycle pop.
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = cpu_we && !full;
    assign drop  = cpu_we && full;
    assign pop   = (state_d == S_WR);

`ifdef VRAM_WR_STEAL_EN
    logic stolen_q, stolen_d;
    // Never steal two slots in a row.
    assign steal      = pix_req && full && !stolen_q;
    assign stolen_d   = pop && pix_req;
    assign pix_stolen = stolen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stolen_q <= 1'b0;
        else        stolen_q <= stolen_d;
    end
`else
    assign steal      = 1'b0;
    assign pix_stolen = 1'b0;
`endif

    // State register plus the registered port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            vram_we_q    <= 1'b0;
            granted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            vram_we_q    <= vram_we_d;
            granted_q    <= granted_d;
        end
    end

    // Next slot selection.
    always_comb begin
        state_d = S_IDLE;
        if (pix_req && !steal) state_d = S_RD;
        else if (!empty)       state_d = S_WR;
    end

    // Port values for the chosen slot; idle holds address and data.
    always_comb begin
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        vram_we_d    = 1'b0;
        granted_d    = 1'b0;
        unique case (state_d)
            S_RD: begin
                vram_addr_d = pix_addr;
                granted_d   = 1'b1;
            end
            S_WR: begin
                vram_addr_d  = addr_mem[rptr_q];
                vram_wdata_d = data_mem[rptr_q];
                vram_we_d    = 1'b1;
            end
            S_IDLE: ;
            default: ;
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // A set in the same cycle as a clear wins.
    assign ovf_d = drop || (ovf_q && !ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr_q] <= cpu_waddr;
            data_mem[wptr_q] <= cpu_wdata;
        end
    end

    assign cpu_ready   = !full;
    assign fifo_level  = level_q;
    assign ovf         = ovf_q;
    assign vram_addr   = vram_addr_q;
    assign vram_we     = vram_we_q;
    assign vram_wdata  = vram_wdata_q;
    assign pix_granted = granted_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of the VRAM read/write arbiter.
// Steal scenario is built when VRAM_WR_STEAL_EN is defined.
module tb_vram_arbiter;

    logic        clk, rst_n;
    logic        pix_req, pix_granted, pix_stolen;
    logic [15:0] pix_addr;
    logic        cpu_we, cpu_ready, ovf, ovf_clr;
    logic [15:0] cpu_waddr;
    logic [11:0] cpu_wdata;
    logic [3:0]  fifo_level;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [11:0] vram_wdata;

    int vectors = 0;
    int misses  = 0;

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .pix_req(pix_req), .pix_addr(pix_addr),
        .pix_granted(pix_granted), .pix_stolen(pix_stolen),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .fifo_level(fifo_level),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pix_req = 1'b0; pix_addr = '0;
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0; ovf_clr = 1'b0;
        repeat (2) step();
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_we", 32'(vram_we), 0);
        chk("rst_gnt", 32'(pix_granted), 0);
        chk("rst_stl", 32'(pix_stolen), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_lvl", 32'(fifo_level), 0);
        chk("rst_rdy", 32'(cpu_ready), 1);
        rst_n = 1'b1;
        step();

        // single write on an idle port
        cpu_we = 1'b1; cpu_waddr = 16'h1234; cpu_wdata = 12'hABC;
        step();
        cpu_we = 1'b0;
        chk("w1_lvl", 32'(fifo_level), 1);
        chk("w1_nobypass", 32'(vram_we), 0);
        step();
        chk("w1_we", 32'(vram_we), 1);
        chk("w1_addr", 32'(vram_addr), 32'h1234);
        chk("w1_data", 32'(vram_wdata), 32'hABC);
        chk("w1_lvl0", 32'(fifo_level), 0);
        step();
        chk("w1_we_off", 32'(vram_we), 0);
        chk("w1_hold", 32'(vram_addr), 32'h1234);

        // continuous reads
        pix_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pix_addr = 16'(i);
            step();
            chk("rd_addr", 32'(vram_addr), 32'(i));
            chk("rd_gnt", 32'(pix_granted), 1);
            chk("rd_we", 32'(vram_we), 0);
        end

`ifndef VRAM_WR_STEAL_EN
        // fill under reads, overflow, then drain
        for (int k = 0; k < 9; k++) begin
            cpu_we = 1'b1;
            cpu_waddr = 16'h100 + 16'(k);
            cpu_wdata = 12'(k + 1);
            chk("of_rdy", 32'(cpu_ready), (k < 8) ? 1 : 0);
            step();
            chk("of_lvl", 32'(fifo_level), (k < 8) ? 32'(k + 1) : 8);
        end
        chk("of_ovf", 32'(ovf), 1);
        chk("of_stl", 32'(pix_stolen), 0);
        chk("of_gnt", 32'(pix_granted), 1);
        cpu_waddr = 16'h1F0; ovf_clr = 1'b1;
        step();
        chk("of_setclr", 32'(ovf), 1);
        chk("of_lvl8", 32'(fifo_level), 8);
        ovf_clr = 1'b0; pix_req = 1'b0; cpu_waddr = 16'h1FF;
        step();
        cpu_we = 1'b0;
        chk("dr_we0", 32'(vram_we), 1);
        chk("dr_addr0", 32'(vram_addr), 32'h100);
        chk("dr_data0", 32'(vram_wdata), 1);
        chk("dr_fullpop", 32'(fifo_level), 7);
        for (int j = 1; j < 8; j++) begin
            step();
            chk("dr_we", 32'(vram_we), 1);
            chk("dr_addr", 32'(vram_addr), 32'h100 + 32'(j));
            chk("dr_data", 32'(vram_wdata), 32'(j + 1));
            chk("dr_lvl", 32'(fifo_level), 32'(7 - j));
        end
        step();
        chk("dr_end", 32'(vram_we), 0);
        chk("dr_ovf", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
`else
        // fill under reads, then steal slots
        for (int k = 0; k < 8; k++) begin
            cpu_we = 1'b1;
            cpu_waddr = 16'h100 + 16'(k);
            cpu_wdata = 12'(k + 1);
            step();
            chk("st_lvl", 32'(fifo_level), 32'(k + 1));
            chk("st_gnt", 32'(pix_granted), 1);
        end
        cpu_we = 1'b0;
        chk("st_rdy", 32'(cpu_ready), 0);
        step();
        chk("st1_we", 32'(vram_we), 1);
        chk("st1_addr", 32'(vram_addr), 32'h100);
        chk("st1_stl", 32'(pix_stolen), 1);
        chk("st1_gnt", 32'(pix_granted), 0);
        chk("st1_lvl", 32'(fifo_level), 7);
        cpu_we = 1'b1; cpu_waddr = 16'h108; cpu_wdata = 12'd9;
        step();
        cpu_we = 1'b0;
        chk("st2_gnt", 32'(pix_granted), 1);
        chk("st2_stl", 32'(pix_stolen), 0);
        chk("st2_lvl", 32'(fifo_level), 8);
        step();
        chk("st3_we", 32'(vram_we), 1);
        chk("st3_addr", 32'(vram_addr), 32'h101);
        chk("st3_stl", 32'(pix_stolen), 1);
        step();
        chk("st4_gnt", 32'(pix_granted), 1);
        chk("st4_lvl", 32'(fifo_level), 7);
        pix_req = 1'b0;
        for (int j = 2; j < 9; j++) begin
            step();
            chk("sd_we", 32'(vram_we), 1);
            chk("sd_addr", 32'(vram_addr), 32'h100 + 32'(j));
            chk("sd_data", 32'(vram_wdata), 32'(j + 1));
            chk("sd_stl", 32'(pix_stolen), 0);
            chk("sd_lvl", 32'(fifo_level), 32'(8 - j));
        end
        step();
        chk("sd_end", 32'(vram_we), 0);
        chk("sd_ovf", 32'(ovf), 0);
`endif

        // reset with queued writes
        pix_req = 1'b1; pix_addr = 16'h55;
        for (int k = 0; k < 5; k++) begin
            cpu_we = 1'b1;
            cpu_waddr = 16'h200 + 16'(k);
            cpu_wdata = 12'h20 + 12'(k);
            step();
        end
        cpu_we = 1'b0;
        chk("pr_lvl", 32'(fifo_level), 5);
        chk("pr_addr", 32'(vram_addr), 32'h55);
        chk("pr_gnt", 32'(pix_granted), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(vram_addr), 0);
        chk("ar_data", 32'(vram_wdata), 0);
        chk("ar_we", 32'(vram_we), 0);
        chk("ar_gnt", 32'(pix_granted), 0);
        chk("ar_stl", 32'(pix_stolen), 0);
        chk("ar_ovf", 32'(ovf), 0);
        chk("ar_lvl", 32'(fifo_level), 0);
        pix_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ar_nowr", 32'(vram_we), 0);
            chk("ar_lvl0", 32'(fifo_level), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
